// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
//   start   : conversion request (master -> slave)
//   bcd_in  : packed BCD {thousands, hundreds, tens, ones} (master -> slave)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   err     : last request held a nibble > 9 (slave -> master)
//   bin_out : 14-bit binary result (slave -> master)
interface bcd_to_binary_seq_if;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] bin_out;

    modport master (output start, output bcd_in,
                    input  busy,  input  done, input err, input bin_out);
    modport slave  (input  start, input  bcd_in,
                    output busy,  output done, output err, output bin_out);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential 4-digit BCD-to-binary converter using reverse double-dabble:
// one right shift plus per-nibble "subtract 3 if >= 8" correction per clock,
// 14 steps per conversion.
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-high reset
//   bus : bcd_to_binary_seq_if.slave (start/bcd_in in, busy/done/err/bin_out out)
module bcd_to_binary_seq (
    input  logic                    clk,
    input  logic                    rst,
    bcd_to_binary_seq_if.slave      bus
);
    localparam int unsigned DIGITS = 4;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned SR_W   = BCD_W + BIN_W;

    typedef enum logic [0:0] {IDLE, CONV} state_t;

    state_t            state;
    state_t            state_next;
    logic [SR_W-1:0]   shift_reg;
    logic [SR_W-1:0]   shifted;
    logic [SR_W-1:0]   step_val;
    logic [3:0]        step_cnt;
    logic              last_step;
    logic              bad_digit;
    logic              done_r;
    logic              err_r;
    logic [BIN_W-1:0]  bin_r;
    logic              busy_c;

    // Any nibble above 9 rejects the request outright.
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // One shift-and-correct step; the correction applies to the shifted value.
    always_comb begin
        shifted  = shift_reg >> 1;
        step_val = shifted;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8)
                step_val[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
        end
    end

    assign last_step = (step_cnt == 4'd13);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start && !bad_digit) state_next = CONV;
            CONV: if (last_step)               state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_c = 1'b0;
        case (state)
            CONV:    busy_c = 1'b1;
            default: busy_c = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            step_cnt  <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            bin_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bad_digit) begin
                            err_r  <= 1'b1;
                            bin_r  <= '0;
                            done_r <= 1'b1;
                        end else begin
                            shift_reg <= {bus.bcd_in, {BIN_W{1'b0}}};
                            step_cnt  <= '0;
                            err_r     <= 1'b0;
                        end
                    end
                end
                CONV: begin
                    shift_reg <= step_val;
                    step_cnt  <= step_cnt + 4'd1;
                    if (last_step) begin
                        bin_r  <= step_val[BIN_W-1:0];
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.bin_out = bin_r;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq.
module tb_bcd_to_binary_seq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   edges;

    bcd_to_binary_seq_if bus ();

    bcd_to_binary_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done or 20 edges have passed; edges counts clocks after E0.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic run_valid(input string tag, input logic [15:0] v, input int exp_bin);
        int n;
        bus.start  = 1'b1;
        bus.bcd_in = v;
        step();
        bus.start  = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        chk({tag, "_latency"}, 32'(n), 32'd14);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_residue"}, 32'(dut.shift_reg[29:14]), 32'd0);
        step();
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_bin", 32'(bus.bin_out), 32'd0);
        chk("rst_sreg", 32'(dut.shift_reg), 32'd0);
        rst = 1'b0;
        step();

        run_valid("v1234", 16'h1234, 1234);

        // Invalid digit: immediate done with err, bin_out forced to 0.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h12A4;
        step();
        bus.start  = 1'b0;
        chk("inv_done", 32'(bus.done), 32'd1);
        chk("inv_err", 32'(bus.err), 32'd1);
        chk("inv_busy", 32'(bus.busy), 32'd0);
        chk("inv_bin", 32'(bus.bin_out), 32'd0);
        step();
        chk("inv_done_drop", 32'(bus.done), 32'd0);
        chk("inv_busy2", 32'(bus.busy), 32'd0);
        chk("inv_err_held", 32'(bus.err), 32'd1);

        // Back-to-back: second start in the done cycle.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h9999;
        step();
        bus.start  = 1'b0;
        chk("b2b_err_clr", 32'(bus.err), 32'd0);
        wait_done(n);
        chk("b2b1_lat", 32'(n), 32'd14);
        chk("b2b1_bin", 32'(bus.bin_out), 32'd9999);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0000;
        step();
        bus.start  = 1'b0;
        chk("b2b2_busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        chk("b2b2_gap", 32'(n + 1), 32'd14 + 32'd1);
        chk("b2b2_bin", 32'(bus.bin_out), 32'd0);
        chk("b2b2_done", 32'(bus.done), 32'd1);
        step();

        // Start during busy is ignored.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0042;
        step();
        bus.start  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0777;
        step();
        bus.start  = 1'b0;
        n = 5;
        while (bus.done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ign_lat", 32'(n), 32'd14);
        chk("ign_bin", 32'(bus.bin_out), 32'd42);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        chk("ign_single_done", 32'(pulses), 32'd0);

        // Asynchronous reset mid-conversion.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h5678;
        step();
        bus.start  = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rmid_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid_busy", 32'(bus.busy), 32'd0);
        chk("rmid_done", 32'(bus.done), 32'd0);
        chk("rmid_err", 32'(bus.err), 32'd0);
        chk("rmid_bin", 32'(bus.bin_out), 32'd0);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        chk("rmid_no_done", 32'(pulses), 32'd0);
        run_valid("v0100", 16'h0100, 100);

        // Strided sweep over the valid range plus the top value.
        for (int v = 0; v < 10000; v += 37) run_valid("sweep", to_bcd(v), v);
        run_valid("sweep_max", to_bcd(9999), 9999);
        run_valid("sweep_1", to_bcd(1), 1);
        run_valid("sweep_8", to_bcd(8), 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
